// File: rtl/program_counter.sv
// Fetch-stage program counter with idle/run/done run control.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | out of reset, outputs hold, waiting for start
// RUN   | one instruction retires per cycle (halt > branch > pc+1)
// DONE  | halt retired, pc and count frozen, waiting for restart
//
// The lookup-table select is a straight wire from the decoder field so the
// branch_sel -> lut_target round trip fits in one cycle.
module program_counter #(
  parameter int              PC_W     = 8,
  parameter int              CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             halt,
  input  logic             branch_en,
  input  logic [1:0]       branch_sel,
  output logic [1:0]       lut_ctrl,
  input  logic [PC_W-1:0]  lut_target,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             running_q;
  logic             done_q;

  // Saturating increment: the count sticks at all-ones rather than wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // State, datapath and run-control flags; all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  // Next-state decode; start only matters outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (halt)  state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Next pc and retired count for the current state.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d  = start_addr;
          cnt_d = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (halt) begin
          pc_d = pc_q;
        end else if (branch_en) begin
          pc_d = lut_target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        pc_d  = RESET_PC;
        cnt_d = '0;
      end
    endcase
  end

  assign lut_ctrl    = branch_sel;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign running     = running_q;
  assign done        = done_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: a default-width instance plus a
// 4-bit-counter instance driven by the same stimulus for saturation.
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_addr;
  logic        halt;
  logic        branch_en;
  logic [1:0]  branch_sel;
  logic [7:0]  lut_target;

  logic [1:0]  lut_ctrl;
  logic [7:0]  pc;
  logic        running;
  logic        done;
  logic [15:0] instr_count;

  logic [1:0]  s_lut_ctrl;
  logic [7:0]  s_pc;
  logic        s_running;
  logic        s_done;
  logic [3:0]  s_instr_count;

  int checks = 0;
  int errors = 0;

  program_counter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .halt        (halt),
    .branch_en   (branch_en),
    .branch_sel  (branch_sel),
    .lut_ctrl    (lut_ctrl),
    .lut_target  (lut_target),
    .pc          (pc),
    .running     (running),
    .done        (done),
    .instr_count (instr_count)
  );

  program_counter #(.CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .halt        (halt),
    .branch_en   (branch_en),
    .branch_sel  (branch_sel),
    .lut_ctrl    (s_lut_ctrl),
    .lut_target  (lut_target),
    .pc          (s_pc),
    .running     (s_running),
    .done        (s_done),
    .instr_count (s_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc, instr_count, running, done} !== {8'h00, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: pc=%h cnt=%h run=%b done=%b want 00 0000 0 0", pc, instr_count, running, done);
    end
    checks++;
    if ({s_pc, s_instr_count} !== {8'h00, 4'h0}) begin
      errors++;
      $display("FAIL reset_async_sat: pc=%h cnt=%h want 00 0", s_pc, s_instr_count);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({pc, instr_count, running, done} !== {8'h00, 16'h0000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle_hold[%0d]: pc=%h cnt=%h run=%b done=%b want 00 0000 0 0", i, pc, instr_count, running, done);
      end
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] exp_pc [4];
    exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    start_addr = 8'hFD;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({pc, instr_count, running, done} !== {8'hFD, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL seq_start: pc=%h cnt=%h run=%b done=%b want fd 0000 1 0", pc, instr_count, running, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pc !== exp_pc[i] || instr_count !== 16'(i + 1)) begin
        errors++;
        $display("FAIL seq_wrap[%0d]: pc=%h cnt=%0d want %h %0d", i, pc, instr_count, exp_pc[i], i + 1);
      end
    end
  endtask

  task automatic test_branch();
    halt = 1'b1;
    step();
    halt = 1'b0;
    checks++;
    if ({pc, instr_count, done} !== {8'h01, 16'd5, 1'b1}) begin
      errors++;
      $display("FAIL branch_prep_halt: pc=%h cnt=%0d done=%b want 01 5 1", pc, instr_count, done);
    end
    start_addr = 8'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    branch_en = 1'b1;
    branch_sel = 2'b10;
    lut_target = 8'h3C;
    #1;
    checks++;
    if (lut_ctrl !== 2'b10 || pc !== 8'h10) begin
      errors++;
      $display("FAIL branch_lut_ctrl: lut_ctrl=%b pc=%h want 10 10", lut_ctrl, pc);
    end
    step();
    checks++;
    if (pc !== 8'h3C || instr_count !== 16'd1) begin
      errors++;
      $display("FAIL branch_take: pc=%h cnt=%0d want 3c 1", pc, instr_count);
    end
    branch_sel = 2'b01;
    lut_target = 8'h55;
    #1;
    checks++;
    if (lut_ctrl !== 2'b01) begin
      errors++;
      $display("FAIL branch_lut_ctrl2: lut_ctrl=%b want 01", lut_ctrl);
    end
    step();
    checks++;
    if (pc !== 8'h55 || instr_count !== 16'd2) begin
      errors++;
      $display("FAIL branch_take2: pc=%h cnt=%0d want 55 2", pc, instr_count);
    end
    branch_sel = 2'b00;
    lut_target = 8'h20;
    step();
    branch_en = 1'b0;
    checks++;
    if (pc !== 8'h20 || instr_count !== 16'd3) begin
      errors++;
      $display("FAIL branch_take3: pc=%h cnt=%0d want 20 3", pc, instr_count);
    end
  endtask

  task automatic test_halt_beats_branch();
    halt = 1'b1;
    branch_en = 1'b1;
    branch_sel = 2'b11;
    lut_target = 8'h77;
    step();
    checks++;
    if ({pc, instr_count, running, done} !== {8'h20, 16'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL halt_priority: pc=%h cnt=%0d run=%b done=%b want 20 4 0 1", pc, instr_count, running, done);
    end
    checks++;
    if (lut_ctrl !== 2'b11) begin
      errors++;
      $display("FAIL done_lut_ctrl: lut_ctrl=%b want 11", lut_ctrl);
    end
    for (int i = 0; i < 3; i++) begin
      halt = i[0];
      branch_en = ~i[0];
      lut_target = 8'h99;
      step();
      checks++;
      if ({pc, instr_count, running, done} !== {8'h20, 16'd4, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL done_hold[%0d]: pc=%h cnt=%0d run=%b done=%b want 20 4 0 1", i, pc, instr_count, running, done);
      end
    end
    halt = 1'b0;
    branch_en = 1'b0;
  endtask

  task automatic test_restart();
    start_addr = 8'h40;
    start = 1'b1;
    step();
    checks++;
    if ({pc, instr_count, running, done} !== {8'h40, 16'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart: pc=%h cnt=%0d run=%b done=%b want 40 0 1 0", pc, instr_count, running, done);
    end
    start_addr = 8'h99;
    step();
    start = 1'b0;
    checks++;
    if ({pc, instr_count, running} !== {8'h41, 16'd1, 1'b1}) begin
      errors++;
      $display("FAIL start_in_run: pc=%h cnt=%0d run=%b want 41 1 1", pc, instr_count, running);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_pc [3];
    exp_pc = '{8'h80, 8'h81, 8'h82};
    halt = 1'b1;
    step();
    halt = 1'b0;
    checks++;
    if ({pc, instr_count, done} !== {8'h41, 16'd2, 1'b1}) begin
      errors++;
      $display("FAIL b2b_halt: pc=%h cnt=%0d done=%b want 41 2 1", pc, instr_count, done);
    end
    start_addr = 8'h80;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== exp_pc[i] || instr_count !== 16'(i) || running !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_held_start[%0d]: pc=%h cnt=%0d run=%b done=%b want %h %0d 1 0", i, pc, instr_count, running, done, exp_pc[i], i);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_saturation();
    halt = 1'b1;
    step();
    halt = 1'b0;
    start_addr = 8'hE0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({s_pc, s_instr_count, s_running} !== {8'hE0, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL sat_start: pc=%h cnt=%h run=%b want e0 0 1", s_pc, s_instr_count, s_running);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (s_instr_count !== ((i < 15) ? 4'(i) : 4'hF) || instr_count !== 16'(i) || pc !== 8'(8'hE0 + i)) begin
        errors++;
        $display("FAIL sat_count[%0d]: small=%h wide=%0d pc=%h want %h %0d %h", i, s_instr_count, instr_count, pc, (i < 15) ? 4'(i) : 4'hF, i, 8'(8'hE0 + i));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc, instr_count, running, done, s_instr_count} !== {8'h00, 16'd0, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_mid_run: pc=%h cnt=%0d run=%b done=%b scnt=%h want 00 0 0 0 0", pc, instr_count, running, done, s_instr_count);
    end
    #2 rst_n = 1'b1;
    branch_en = 1'b1;
    lut_target = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pc, instr_count, running, done} !== {8'h00, 16'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: pc=%h cnt=%0d run=%b done=%b want 00 0 0 0", i, pc, instr_count, running, done);
      end
    end
    branch_en = 1'b0;
    start_addr = 8'h05;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({pc, running, done} !== {8'h05, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_start: pc=%h run=%b done=%b want 05 1 0", pc, running, done);
    end
  endtask

  initial begin
    start = 1'b0;
    start_addr = 8'h00;
    halt = 1'b0;
    branch_en = 1'b0;
    branch_sel = 2'b00;
    lut_target = 8'h00;
    test_reset();
    test_seq_wrap();
    test_branch();
    test_halt_beats_branch();
    test_restart();
    test_back_to_back();
    test_saturation();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Fetch-stage program counter for the single-cycle CPU. It holds the 8-bit instruction address, and each cycle it either advances sequentially, jumps to a branch target, or stops on halt. It sits directly upstream of the branch lookup table: it drives the table's 2-bit select and consumes the 8-bit target it returns. It also sequences run control (idle, run, done) and counts retired instructions for the test bench.

## Interface
- PC_W, 8, program counter width; must match the lookup table's target width
- CNT_W, 16, retired-instruction counter width
- RESET_PC, 8'h00, PC value loaded on reset

- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  start request; sampled only in IDLE and DONE
- start_addr  input  PC_W  PC loaded when start is accepted
- halt  input  1  decoder flag: the instruction at pc is a halt
- branch_en  input  1  decoder flag: the instruction at pc is a taken branch
- branch_sel  input  2  decoder field selecting one of 4 branch targets
- lut_ctrl  output  2  select to the lookup table; combinational copy of branch_sel
- lut_target  input  PC_W  target address returned by the lookup table (combinational path)
- pc  output  PC_W  current instruction address, registered
- running  output  1  high while in RUN, registered
- done  output  1  high while in DONE, registered
- instr_count  output  CNT_W  instructions retired since the last accepted start, registered

## Operation
- Three-state FSM: IDLE, RUN, DONE.
- **Reset** (rst_n low, asynchronous):
  - state goes to IDLE
  - pc = RESET_PC, instr_count = 0, running = 0, done = 0
- **IDLE**: all outputs hold. When start = 1: pc <= start_addr, instr_count <= 0, go to RUN.
- **RUN**: one instruction retires per cycle. Priority is halt > branch_en > sequential.
  - halt = 1: instr_count increments (the halt instruction counts); pc holds; go to DONE. branch_en is ignored.
  - else branch_en = 1: pc <= lut_target; instr_count increments.
  - else: pc <= pc + 1, wrapping modulo 2^PC_W (8'hFF -> 8'h00); instr_count increments.
  - start is ignored in RUN.
- **DONE**: pc and instr_count hold; halt and branch_en are ignored. When start = 1: pc <= start_addr, instr_count <= 0, go to RUN.
- **instr_count** saturates at all-ones. It never wraps.
- **lut_ctrl** = branch_sel in every state, with no gating.
- **running / done** are registered decodes of the next state. They update on the same edge as the state and are never both high.

## Timing
- pc updates on the rising clk edge following the cycle in which the decoder flags are presented. Branch latency is 1 cycle: branch_en sampled at edge N gives pc = lut_target after edge N.
- The combinational path branch_sel -> lut_ctrl -> (lookup table) -> lut_target must settle within one clock period.
- start is accepted on the edge where it is sampled. running rises after that edge, and the first instruction executes in the following cycle.
- halt at edge N: done = 1 and running = 0 after edge N, and pc still shows the halt address.
- Reset mid-RUN takes effect immediately, without waiting for clk. After rst_n is released, the block stays in IDLE until start.
- start held high continuously in DONE restarts on the first edge, then is ignored while in RUN.

## Test plan
- **Reset**: assert rst_n = 0 mid-cycle -> pc = 00, instr_count = 0, running = 0, done = 0 immediately; with start = 0 for 5 cycles, the outputs stay unchanged.
- **Sequential run and wrap**: start with start_addr = 8'hFD, no branch/halt for 4 cycles -> pc sequence FD, FE, FF, 00, 01 and instr_count = 4.
- **Branch**: in RUN with pc = 10, branch_en = 1, branch_sel = 2'b10, lut_target = 8'h3C -> lut_ctrl = 2'b10 in the same cycle; pc = 3C after the edge; instr_count increments by 1.
- **Halt beats branch**: halt = 1 and branch_en = 1 together at pc = 20 -> pc stays 20, done = 1, running = 0, instr_count increments by 1. Further branch/halt pulses then cause no change.
- **Restart from DONE**: start with start_addr = 8'h40 -> pc = 40, instr_count = 0, running = 1, done = 0. A start pulse during RUN has no effect.
- **Saturation and reset mid-run**: with CNT_W = 4, run 20 cycles -> instr_count stops at 4'hF. Then drop rst_n during RUN -> instant return to reset values and IDLE.
